contador_bcd: RTL and testbench
===============================

CONTADOR_BCD -- requirements
Module: contador_bcd

Interface
REQ-001 SHALL have parameter: DIV, 50000000, clock cycles per count tick (legal range 2..2^26).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: start  input  1  level input; a rising edge starts or resumes counting.
REQ-005 SHALL have port: stop  input  1  level input; a rising edge pauses counting.
REQ-006 SHALL have port: clr  input  1  level; returns the block to IDLE with digits 00.
REQ-007 SHALL have port: dir  input  1  count direction: 1 = up, 0 = down.
REQ-008 SHALL have port: load  input  1  level; loads load_val when not RUN.
REQ-009 SHALL have port: load_val  input  8  [7:4] tens BCD, [3:0] units BCD.
REQ-010 SHALL have port: unid  output  4  units BCD digit, 0..9, registered; drives a seven-segment decoder.
REQ-011 SHALL have port: dez  output  4  tens BCD digit, 0..9, registered.
REQ-012 SHALL have port: tc  output  1  one-cycle terminal-count pulse on wrap.
REQ-013 SHALL have port: running  output  1  high while the FSM is in RUN.

Function
REQ-014 SHALL register start and stop once each (start_q, stop_q): start_rise = start & ~start_q; stop_rise = stop & ~stop_q.
REQ-015 SHALL implement a 3-state FSM: IDLE, RUN, HOLD.
REQ-016 SHALL make the following transitions: IDLE->RUN on start_rise; RUN->HOLD on stop_rise; HOLD->RUN on start_rise; any state->IDLE on clr. All other cases hold the current state.
REQ-017 SHALL apply the priority clr > stop_rise > start_rise, so a start_rise and stop_rise in the same cycle while in RUN yields HOLD, and in IDLE/HOLD yields no transition.
REQ-018 SHALL, on clr, set unid and dez to 0 and the prescaler to 0 in the same edge.
REQ-019 SHALL, in RUN, have the prescaler count 0..DIV-1 and wrap to 0; tick = (prescaler == DIV-1) & RUN.
REQ-020 SHALL hold the prescaler value in HOLD, so resume continues the partial period, and SHALL force the prescaler to 0 in IDLE.
REQ-021 SHALL, on tick with dir=1, increment units; units 9 rolls to 0 and increments tens; 99 rolls to 00.
REQ-022 SHALL, on tick with dir=0, decrement units; units 0 rolls to 9 and decrements tens; 00 rolls to 99.
REQ-023 SHALL sample dir only on the tick cycle; dir changes between ticks have no other effect.
REQ-024 SHALL make new digits visible on the outputs in the cycle after the tick edge (one-cycle latency).
REQ-025 SHALL assert tc for exactly one cycle, coincident with the updated digits, when a tick causes 99->00 (up) or 00->99 (down); otherwise tc = 0.
REQ-026 SHALL apply load only in IDLE or HOLD, with clr taking precedence: unid <= load_val[3:0], dez <= load_val[7:4]; load is ignored in RUN.
REQ-027 SHALL force any loaded nibble > 9 to 0 independently per digit (e.g. 8'hA7 loads 07), so unid and dez never leave 0..9.
REQ-028 SHALL drive running combinationally from the state register: running = (state == RUN).

Reset
REQ-029 SHALL, when rst_n = 0 at a rising clk edge, set state = IDLE, prescaler = 0, unid = 0, dez = 0, tc = 0, start_q = 0, stop_q = 0.
REQ-030 SHALL give reset priority over all inputs, including clr, load and edges in the same cycle, and SHALL let reset asserted mid-RUN or mid-HOLD abort without a tc pulse.
REQ-031 SHALL NOT register a start_rise after reset from a start held high through reset until start goes low and high again (start_q samples start while rst_n is high).

Verification (DIV = 4)
REQ-032 SHALL cover: reset, then start pulse, dir=1 -> running=1, digits 01 after 4 cycles, 10 after 40 cycles, one tick every 4 cycles.
REQ-033 SHALL cover: load 8'h98 in IDLE, start, dir=1 -> 99, then 00 with tc=1 for exactly one cycle.
REQ-034 SHALL cover: 00 in HOLD, dir=0, start -> first tick gives 99 and tc=1.
REQ-035 SHALL cover: stop_rise 2 cycles into a period, wait 10 cycles, start_rise -> next tick 2 cycles after resume; digits frozen while in HOLD.
REQ-036 SHALL cover: simultaneous start_rise and stop_rise in RUN -> HOLD; clr with load=1 -> IDLE, digits 00; load 8'hAB -> 00.
REQ-037 SHALL cover: rst_n=0 mid-RUN at 57 -> next cycle digits 00, running=0, tc=0; start held high through reset -> no count until it is re-pulsed.

Source files
------------

// File: rtl/contador_bcd.sv
// Two-digit BCD up/down counter with start/stop/hold control and a clock prescaler.
// Digits are always kept in 0..9 so they can feed a seven-segment decoder directly.
module contador_bcd #(
    parameter int DIV = 50000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       clr,
    input  logic       dir,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [3:0] unid,
    output logic [3:0] dez,
    output logic       tc,
    output logic       running
);

    localparam int PW = $clog2(DIV);
    localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PW-1:0]   r_presc;
    logic [PW-1:0]   w_presc_nxt;
    logic [3:0]      r_unid;
    logic [3:0]      w_unid_nxt;
    logic [3:0]      r_dez;
    logic [3:0]      w_dez_nxt;
    logic            r_tc;
    logic            w_tc_nxt;
    logic            r_start_q;
    logic            r_stop_q;
    logic            r_start_armed;
    logic            w_start_rise;
    logic            w_stop_rise;
    logic            w_tick;

    function automatic logic [3:0] bcdClamp(input logic [3:0] n);
        return (n > 4'd9) ? 4'd0 : n;
    endfunction

    // A start held high through reset must be seen low once before it can count as a rising edge.
    assign w_start_rise = start & ~r_start_q & r_start_armed;
    assign w_stop_rise  = stop & ~r_stop_q;
    assign w_tick       = (r_state == RUN) && (r_presc == PMAX);

    always_comb begin
        w_state_nxt = r_state;
        if (clr) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_start_rise && !w_stop_rise) w_state_nxt = RUN;
                RUN:     if (w_stop_rise) w_state_nxt = HOLD;
                HOLD:    if (w_start_rise && !w_stop_rise) w_state_nxt = RUN;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        w_presc_nxt = r_presc;
        w_unid_nxt  = r_unid;
        w_dez_nxt   = r_dez;
        w_tc_nxt    = 1'b0;
        if (clr) begin
            w_presc_nxt = '0;
            w_unid_nxt  = 4'd0;
            w_dez_nxt   = 4'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_presc_nxt = '0;
                    if (load) begin
                        w_unid_nxt = bcdClamp(load_val[3:0]);
                        w_dez_nxt  = bcdClamp(load_val[7:4]);
                    end
                end
                HOLD: begin
                    if (load) begin
                        w_unid_nxt = bcdClamp(load_val[3:0]);
                        w_dez_nxt  = bcdClamp(load_val[7:4]);
                    end
                end
                RUN: begin
                    w_presc_nxt = w_tick ? '0 : r_presc + PW'(1);
                    if (w_tick) begin
                        if (dir) begin
                            if (r_unid == 4'd9) begin
                                w_unid_nxt = 4'd0;
                                if (r_dez == 4'd9) begin
                                    w_dez_nxt = 4'd0;
                                    w_tc_nxt  = 1'b1;
                                end else begin
                                    w_dez_nxt = r_dez + 4'd1;
                                end
                            end else begin
                                w_unid_nxt = r_unid + 4'd1;
                            end
                        end else begin
                            if (r_unid == 4'd0) begin
                                w_unid_nxt = 4'd9;
                                if (r_dez == 4'd0) begin
                                    w_dez_nxt = 4'd9;
                                    w_tc_nxt  = 1'b1;
                                end else begin
                                    w_dez_nxt = r_dez - 4'd1;
                                end
                            end else begin
                                w_unid_nxt = r_unid - 4'd1;
                            end
                        end
                    end
                end
                default: w_presc_nxt = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_presc       <= '0;
            r_unid        <= 4'd0;
            r_dez         <= 4'd0;
            r_tc          <= 1'b0;
            r_start_q     <= 1'b0;
            r_stop_q      <= 1'b0;
            r_start_armed <= ~start;
        end else begin
            r_state       <= w_state_nxt;
            r_presc       <= w_presc_nxt;
            r_unid        <= w_unid_nxt;
            r_dez         <= w_dez_nxt;
            r_tc          <= w_tc_nxt;
            r_start_q     <= start;
            r_stop_q      <= stop;
            r_start_armed <= r_start_armed | ~start;
        end
    end

    assign unid    = r_unid;
    assign dez     = r_dez;
    assign tc      = r_tc;
    assign running = (r_state == RUN);

endmodule

// File: tb/tb_contador_bcd.sv
// Self-checking bench for contador_bcd with DIV = 4: a vector table for control and load
// behaviour, followed by hand-written sequences for counting, hold/resume and reset abort.
module tb_contador_bcd;

    typedef struct {
        string      name;
        logic       rstN;
        logic       start;
        logic       stop;
        logic       clr;
        logic       dir;
        logic       load;
        logic [7:0] loadVal;
        logic [3:0] expUnid;
        logic [3:0] expDez;
        logic       expTc;
        logic       expRunning;
    } vec_t;

    logic       clk;
    logic       rstN;
    logic       start;
    logic       stop;
    logic       clr;
    logic       dir;
    logic       load;
    logic [7:0] loadVal;
    logic [3:0] unid;
    logic [3:0] dez;
    logic       tc;
    logic       running;

    int   passCount   = 0;
    int   totalChecks = 0;
    vec_t vecs[$];

    contador_bcd #(.DIV(4)) dut (
        .clk      (clk),
        .rst_n    (rstN),
        .start    (start),
        .stop     (stop),
        .clr      (clr),
        .dir      (dir),
        .load     (load),
        .load_val (loadVal),
        .unid     (unid),
        .dez      (dez),
        .tc       (tc),
        .running  (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic addVec(input string name, input logic r, input logic sa, input logic so,
                          input logic c, input logic d, input logic l, input logic [7:0] lv,
                          input logic [3:0] eu, input logic [3:0] ed, input logic et,
                          input logic er);
        vec_t v;
        v.name = name; v.rstN = r; v.start = sa; v.stop = so; v.clr = c; v.dir = d;
        v.load = l; v.loadVal = lv; v.expUnid = eu; v.expDez = ed; v.expTc = et;
        v.expRunning = er;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input vec_t v);
        rstN    = v.rstN;
        start   = v.start;
        stop    = v.stop;
        clr     = v.clr;
        dir     = v.dir;
        load    = v.load;
        loadVal = v.loadVal;
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] eu, input logic [3:0] ed,
                               input logic et, input logic er);
        totalChecks++;
        if (unid === eu && dez === ed && tc === et && running === er) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got dez=%0d unid=%0d tc=%0b running=%0b, expected dez=%0d unid=%0d tc=%0b running=%0b",
                     name, dez, unid, tc, running, ed, eu, et, er);
        end
    endtask

    // Watchdog so the run always ends even if the clock stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int n;
        rstN = 1'b0; start = 1'b0; stop = 1'b0; clr = 1'b0;
        dir = 1'b1; load = 1'b0; loadVal = 8'h00;

        //      name               rst sa so clr dir ld  loadVal  unid  dez  tc  run
        addVec("reset",            0, 0, 0, 0, 1, 0, 8'h00, 4'd0, 4'd0, 0, 0);
        addVec("load98",           1, 0, 0, 0, 1, 1, 8'h98, 4'd8, 4'd9, 0, 0);
        addVec("loadA7clamp",      1, 0, 0, 0, 1, 1, 8'hA7, 4'd7, 4'd0, 0, 0);
        addVec("loadABclamp",      1, 0, 0, 0, 1, 1, 8'hAB, 4'd0, 4'd0, 0, 0);
        addVec("load3Cclamp",      1, 0, 0, 0, 1, 1, 8'h3C, 4'd0, 4'd3, 0, 0);
        addVec("load98again",      1, 0, 0, 0, 1, 1, 8'h98, 4'd8, 4'd9, 0, 0);
        addVec("startRun",         1, 1, 0, 0, 1, 0, 8'h00, 4'd8, 4'd9, 0, 1);
        addVec("loadIgnoredRun",   1, 1, 0, 0, 1, 1, 8'h11, 4'd8, 4'd9, 0, 1);
        addVec("presc2",           1, 0, 0, 0, 1, 0, 8'h00, 4'd8, 4'd9, 0, 1);
        addVec("presc3",           1, 0, 0, 0, 1, 0, 8'h00, 4'd8, 4'd9, 0, 1);
        addVec("tickTo99",         1, 0, 0, 0, 1, 0, 8'h00, 4'd9, 4'd9, 0, 1);
        addVec("at99a",            1, 0, 0, 0, 1, 0, 8'h00, 4'd9, 4'd9, 0, 1);
        addVec("at99b",            1, 0, 0, 0, 1, 0, 8'h00, 4'd9, 4'd9, 0, 1);
        addVec("at99c",            1, 0, 0, 0, 1, 0, 8'h00, 4'd9, 4'd9, 0, 1);
        addVec("wrapUpTc",         1, 0, 0, 0, 1, 0, 8'h00, 4'd0, 4'd0, 1, 1);
        addVec("tcOneCycle",       1, 0, 0, 0, 1, 0, 8'h00, 4'd0, 4'd0, 0, 1);
        addVec("startStopInRun",   1, 1, 1, 0, 1, 0, 8'h00, 4'd0, 4'd0, 0, 0);
        addVec("holdStays",        1, 0, 0, 0, 0, 0, 8'h00, 4'd0, 4'd0, 0, 0);
        addVec("resumeDown",       1, 1, 0, 0, 0, 0, 8'h00, 4'd0, 4'd0, 0, 1);
        addVec("resumePresc3",     1, 1, 0, 0, 0, 0, 8'h00, 4'd0, 4'd0, 0, 1);
        addVec("wrapDownTc",       1, 1, 0, 0, 0, 0, 8'h00, 4'd9, 4'd9, 1, 1);
        addVec("afterWrapDown",    1, 0, 0, 0, 1, 0, 8'h00, 4'd9, 4'd9, 0, 1);
        addVec("clrBeatsLoad",     1, 0, 0, 1, 1, 1, 8'h55, 4'd0, 4'd0, 0, 0);
        addVec("load42",           1, 0, 0, 0, 1, 1, 8'h42, 4'd2, 4'd4, 0, 0);
        addVec("startStopInIdle",  1, 1, 1, 0, 1, 0, 8'h00, 4'd2, 4'd4, 0, 0);
        addVec("idleQuiet",        1, 0, 0, 0, 1, 0, 8'h00, 4'd2, 4'd4, 0, 0);
        addVec("resetBeatsAll",    0, 1, 0, 1, 1, 1, 8'h77, 4'd0, 4'd0, 0, 0);
        addVec("startHeldNoRise",  1, 1, 0, 0, 1, 0, 8'h00, 4'd0, 4'd0, 0, 0);
        addVec("startReleased",    1, 0, 0, 0, 1, 0, 8'h00, 4'd0, 4'd0, 0, 0);
        addVec("startRepulsed",    1, 1, 0, 0, 1, 0, 8'h00, 4'd0, 4'd0, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            stepClock();
            checkOutput(vecs[i].name, vecs[i].expUnid, vecs[i].expDez, vecs[i].expTc,
                        vecs[i].expRunning);
        end

        // Fresh reset, one start pulse, then count up for 40 cycles: one tick per 4 cycles.
        rstN = 1'b0; start = 1'b0; stop = 1'b0; clr = 1'b0; load = 1'b0; dir = 1'b1;
        stepClock();
        rstN = 1'b1;
        start = 1'b1;
        stepClock();
        checkOutput("upStart", 4'd0, 4'd0, 1'b0, 1'b1);
        start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            stepClock();
            n = k / 4;
            checkOutput($sformatf("upCount k=%0d", k), 4'(n % 10), 4'(n / 10), 1'b0, 1'b1);
        end

        // Pause two cycles into a period, sit in HOLD, then resume the partial period.
        stepClock();
        stop = 1'b1;
        stepClock();
        checkOutput("holdEnter", 4'd0, 4'd1, 1'b0, 1'b0);
        stop = 1'b0;
        for (int k = 0; k < 10; k++) begin
            stepClock();
            checkOutput($sformatf("holdFrozen k=%0d", k), 4'd0, 4'd1, 1'b0, 1'b0);
        end
        start = 1'b1;
        stepClock();
        checkOutput("resume", 4'd0, 4'd1, 1'b0, 1'b1);
        start = 1'b0;
        stepClock();
        checkOutput("resumeNoTickYet", 4'd0, 4'd1, 1'b0, 1'b1);
        stepClock();
        checkOutput("resumeTick", 4'd1, 4'd1, 1'b0, 1'b1);

        // Count down from 11 through the tens borrow to 09.
        dir = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            stepClock();
            n = 11 - (k / 4);
            checkOutput($sformatf("downCount k=%0d", k), 4'(n % 10), 4'(n / 10), 1'b0, 1'b1);
        end

        // Load 99 in HOLD, resume counting up, then reset on the wrapping tick: no tc.
        stop = 1'b1;
        stepClock();
        checkOutput("holdAt09", 4'd9, 4'd0, 1'b0, 1'b0);
        stop = 1'b0; dir = 1'b1; load = 1'b1; loadVal = 8'h99;
        stepClock();
        checkOutput("loadInHold", 4'd9, 4'd9, 1'b0, 1'b0);
        load = 1'b0; start = 1'b1;
        stepClock();
        checkOutput("resume99", 4'd9, 4'd9, 1'b0, 1'b1);
        start = 1'b0;
        stepClock();
        checkOutput("run99a", 4'd9, 4'd9, 1'b0, 1'b1);
        stepClock();
        checkOutput("run99b", 4'd9, 4'd9, 1'b0, 1'b1);
        rstN = 1'b0;
        stepClock();
        checkOutput("resetAbort", 4'd0, 4'd0, 1'b0, 1'b0);
        rstN = 1'b1;
        stepClock();
        checkOutput("afterAbort", 4'd0, 4'd0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passCount, totalChecks);
        $finish;
    end

endmodule
